// File: rtl/triangle_raster_scan.sv
// Triangle rasterizer: sweeps pixels in raster order and flags each one inside/outside via shoelace areas.
// Optional TRI_BBOX_EN restricts the sweep to the clamped vertex bounding box (default: full screen).
module triangle_raster_scan #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [8:0]  ax,
    input  logic [8:0]  ay,
    input  logic [8:0]  bx,
    input  logic [8:0]  by,
    input  logic [8:0]  cx,
    input  logic [8:0]  cy,
    output logic        busy,
    output logic        done,
    output logic [17:0] tri_area,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_x,
    output logic [8:0]  out_y,
    output logic        out_inside
);

    localparam int unsigned CW = 9;
    localparam int unsigned PW = 18;
    localparam int unsigned DW = 20;
    localparam int unsigned AW = 19;
    localparam int unsigned SW = 21;
    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, FLUSH} state_t;

    // |doubled signed area| of (1,2,3); the true value always fits the 20-bit signed range
    function automatic logic [AW-1:0] abs_det(input logic [CW-1:0] x1, input logic [CW-1:0] y1,
                                              input logic [CW-1:0] x2, input logic [CW-1:0] y2,
                                              input logic [CW-1:0] x3, input logic [CW-1:0] y3);
        logic [DW-1:0] pos;
        logic [DW-1:0] neg;
        logic [DW-1:0] d;
        pos = DW'(PW'(x1) * PW'(y2)) + DW'(PW'(y1) * PW'(x3)) + DW'(PW'(x2) * PW'(y3));
        neg = DW'(PW'(y1) * PW'(x2)) + DW'(PW'(x1) * PW'(y3)) + DW'(PW'(y2) * PW'(x3));
        d   = pos - neg;
        return d[DW-1] ? AW'(-d) : AW'(d);
    endfunction

`ifdef TRI_BBOX_EN
    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [CW-1:0]   ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
    logic [AW-1:0]   area_q, area_d;
    logic            skip_q, skip_d;
    logic [CW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [CW-1:0]   px_q, px_d, py_q, py_d;
    logic            s1_valid_q, s1_valid_d;
    logic [CW-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [AW-1:0]   s1_a0_q, s1_a0_d, s1_a1_q, s1_a1_d, s1_a2_q, s1_a2_d;
    logic            out_valid_q, out_valid_d, out_inside_q, out_inside_d;
    logic [CW-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]   bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic            bb_empty;
    logic            stall_c, issue_c;
    logic [AW-1:0]   tri_abs;

    // Scan window from the registered vertices
    always_comb begin
`ifdef TRI_BBOX_EN
        logic [CW-1:0] xm;
        logic [CW-1:0] ym;
        xm       = max3(ax_q, bx_q, cx_q);
        ym       = max3(ay_q, by_q, cy_q);
        bb_xmin  = min3(ax_q, bx_q, cx_q);
        bb_ymin  = min3(ay_q, by_q, cy_q);
        bb_xmax  = (xm > X_LAST) ? X_LAST : xm;
        bb_ymax  = (ym > Y_LAST) ? Y_LAST : ym;
        bb_empty = (bb_xmin > X_LAST) || (bb_ymin > Y_LAST);
`else
        bb_xmin  = '0;
        bb_ymin  = '0;
        bb_xmax  = X_LAST;
        bb_ymax  = Y_LAST;
        bb_empty = 1'b0;
`endif
    end

    // Next-state, pixel counter and two-stage inside/outside pipeline
    always_comb begin
        state_d      = state_q;
        ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q; cx_d = cx_q; cy_d = cy_q;
        area_d       = area_q;
        skip_d       = skip_q;
        xmin_d       = xmin_q;
        xmax_d       = xmax_q;
        ymax_d       = ymax_q;
        px_d         = px_q;
        py_d         = py_q;
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s1_a0_d      = s1_a0_q;
        s1_a1_d      = s1_a1_q;
        s1_a2_d      = s1_a2_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_inside_d = out_inside_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue_c      = 1'b0;
        stall_c      = out_valid_q & ~out_ready;
        tri_abs      = abs_det(ax_q, ay_q, bx_q, by_q, cx_q, cy_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    ax_d = ax; ay_d = ay; bx_d = bx; by_d = by; cx_d = cx; cy_d = cy;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                area_d  = tri_abs;
                skip_d  = (tri_abs == '0) || bb_empty;
                xmin_d  = bb_xmin;
                xmax_d  = bb_xmax;
                ymax_d  = bb_ymax;
                px_d    = bb_xmin;
                py_d    = bb_ymin;
                state_d = SCAN;
            end
            SCAN: begin
                if (skip_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!stall_c) begin
                    issue_c = 1'b1;
                    if (px_q == xmax_q) begin
                        px_d = xmin_q;
                        py_d = py_q + CW'(1);
                        if (py_q == ymax_q) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        px_d = px_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready && !s1_valid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!stall_c) begin
            s1_valid_d   = issue_c;
            s1_x_d       = px_q;
            s1_y_d       = py_q;
            s1_a0_d      = abs_det(px_q, py_q, bx_q, by_q, cx_q, cy_q);
            s1_a1_d      = abs_det(ax_q, ay_q, px_q, py_q, cx_q, cy_q);
            s1_a2_d      = abs_det(ax_q, ay_q, bx_q, by_q, px_q, py_q);
            out_valid_d  = s1_valid_q;
            out_x_d      = s1_x_q;
            out_y_d      = s1_y_q;
            out_inside_d = (SW'(s1_a0_q) + SW'(s1_a1_q) + SW'(s1_a2_q)) == SW'(area_q);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
            area_q       <= '0;
            skip_q       <= 1'b0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            px_q         <= '0;
            py_q         <= '0;
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_a0_q      <= '0;
            s1_a1_q      <= '0;
            s1_a2_q      <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_inside_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d; cx_q <= cx_d; cy_q <= cy_d;
            area_q       <= area_d;
            skip_q       <= skip_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymax_q       <= ymax_d;
            px_q         <= px_d;
            py_q         <= py_d;
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_a0_q      <= s1_a0_d;
            s1_a1_q      <= s1_a1_d;
            s1_a2_q      <= s1_a2_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_inside_q <= out_inside_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign tri_area   = area_q[17:0];
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_inside = out_inside_q;

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Scoreboard bench for triangle_raster_scan: expected pixel records are queued at start and
// popped on each output handshake; latency, done timing and stall hold behaviour are also checked.
module tb_triangle_raster_scan;

    localparam int H_RES = 320;
    localparam int V_RES = 240;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        start    = 1'b0;
    logic [8:0]  ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
    logic        busy, done, out_valid, out_inside;
    logic        out_ready = 1'b1;
    logic [17:0] tri_area;
    logic [8:0]  out_x, out_y;

    int n_vec = 0;
    int n_err = 0;
    logic [18:0] sb[$];

    triangle_raster_scan #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .start      (start),
        .ax         (ax),
        .ay         (ay),
        .bx         (bx),
        .by         (by),
        .cx         (cx),
        .cy         (cy),
        .busy       (busy),
        .done       (done),
        .tri_area   (tri_area),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_inside (out_inside)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int edge_fn(input int x1, input int y1, input int x2, input int y2,
                                   input int px, input int py);
        return (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
    endfunction

    // Queue the expected records; returns record count and expected tri_area
    task automatic build_expect(input int vax, input int vay, input int vbx, input int vby,
                                input int vcx, input int vcy, output int nrec, output int area);
        int d, x0, x1, y0, y1;
        d = (vax * vby + vay * vcx + vbx * vcy) - (vay * vbx + vax * vcy + vby * vcx);
        if (d < 0) d = -d;
        area = d & 32'h3FFFF;
        nrec = 0;
`ifdef TRI_BBOX_EN
        x0 = vax; if (vbx < x0) x0 = vbx; if (vcx < x0) x0 = vcx;
        y0 = vay; if (vby < y0) y0 = vby; if (vcy < y0) y0 = vcy;
        x1 = vax; if (vbx > x1) x1 = vbx; if (vcx > x1) x1 = vcx;
        y1 = vay; if (vby > y1) y1 = vby; if (vcy > y1) y1 = vcy;
        if (x1 > H_RES - 1) x1 = H_RES - 1;
        if (y1 > V_RES - 1) y1 = V_RES - 1;
`else
        x0 = 0; y0 = 0; x1 = H_RES - 1; y1 = V_RES - 1;
`endif
        if (d == 0 || x0 > H_RES - 1 || y0 > V_RES - 1) return;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                int w0, w1, w2;
                logic ins;
                w0 = edge_fn(vax, vay, vbx, vby, x, y);
                w1 = edge_fn(vbx, vby, vcx, vcy, x, y);
                w2 = edge_fn(vcx, vcy, vax, vay, x, y);
                ins = (w0 >= 0 && w1 >= 0 && w2 >= 0) || (w0 <= 0 && w1 <= 0 && w2 <= 0);
                sb.push_back({9'(x), 9'(y), ins});
                nrec++;
            end
        end
    endtask

    // Run one triangle; abort_after >= 0 returns after that many records (for the reset test)
    task automatic run_tri(input int vax, input int vay, input int vbx, input int vby,
                           input int vcx, input int vcy, input int stall_at, input int stall_len,
                           input bit rnd, input int abort_after);
        int nrec, area, k, first_v, done_k, rec, stalls, stall_cnt, limit;
        bit was_stalled, r;
        logic [18:0] held, exp_rec;
        build_expect(vax, vay, vbx, vby, vcx, vcy, nrec, area);
        @(negedge CLOCK_50);
        ax = 9'(vax); ay = 9'(vay); bx = 9'(vbx); by = 9'(vby); cx = 9'(vcx); cy = 9'(vcy);
        start = 1'b1;
        @(posedge CLOCK_50);
        k = 0; first_v = -1; done_k = -1; rec = 0; stalls = 0; stall_cnt = 0;
        was_stalled = 1'b0; held = '0;
        limit = 3 * nrec + 40;
        while (k < limit) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            ax = 9'($urandom); bx = 9'($urandom); cy = 9'($urandom);
            if (abort_after >= 0 && rec >= abort_after) return;
            if (k == 1) begin
                check("tri_area", 64'(tri_area), 64'(area));
                check("busy_on", 64'(busy), 64'(1));
            end
            if (was_stalled) check("stall_hold", 64'({out_x, out_y, out_inside}), 64'(held));
            if (out_valid && first_v < 0) first_v = k;
            if (done) begin
                done_k = k;
                break;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && rec == stall_at && stall_cnt < stall_len) begin
                r = 1'b0;
                stall_cnt++;
            end
            out_ready = r;
            was_stalled = 1'b0;
            if (out_valid && r) begin
                if (sb.size() == 0) begin
                    check("extra_record", 64'({out_x, out_y, out_inside}), 64'h7FFFF_FFFF);
                end else begin
                    exp_rec = sb.pop_front();
                    check("record", 64'({out_x, out_y, out_inside}), 64'(exp_rec));
                end
                rec++;
            end else if (out_valid) begin
                stalls++;
                was_stalled = 1'b1;
                held = {out_x, out_y, out_inside};
            end
            @(posedge CLOCK_50);
            k++;
        end
        check("done_cycle", 64'(done_k), (nrec > 0) ? 64'(3 + nrec + stalls) : 64'(2));
        check("first_valid", 64'(first_v), (nrec > 0) ? 64'(3) : 64'(-1));
        check("record_count", 64'(rec), 64'(nrec));
        check("busy_off", 64'(busy), 64'(0));
        check("sb_empty", 64'(sb.size()), 64'(0));
        out_ready = 1'b1;
        @(negedge CLOCK_50);
        check("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({busy, done, out_valid, out_inside, out_x, out_y, tri_area}), 64'(0));
    endtask

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 check_reset_outputs("reset_state");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

`ifdef TRI_BBOX_EN
        run_tri(0, 0, 4, 0, 0, 4, -1, 0, 1'b0, -1);
`endif
        run_tri(0, 0, 2, 2, 4, 4, -1, 0, 1'b0, -1);
`ifdef TRI_BBOX_EN
        run_tri(300, 200, 400, 200, 300, 239, -1, 0, 1'b0, -1);
        run_tri(400, 10, 450, 10, 400, 50, -1, 0, 1'b0, -1);
        run_tri(10, 5, 17, 9, 12, 14, 3, 4, 1'b1, -1);
`endif

        // Reset mid-scan, then a full triangle with a 5-cycle stall on the 3rd record
        run_tri(0, 0, 4, 0, 0, 4, -1, 0, 1'b0, 5);
        sb.delete();
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1 check_reset_outputs("reset_mid_scan");
        repeat (2) @(posedge CLOCK_50);
        #1 check_reset_outputs("reset_held");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        out_ready = 1'b1;
        run_tri(0, 0, 4, 0, 0, 4, 2, 5, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
